int_injector: RTL and testbench

- Synthesizable, multi-channel interrupt stimulus generator for the P7 MIPS system bench. It replaces the single hard-coded "fire once at target PC" logic.
- Holds NUM_TRIG programmable PC triggers, each with its own fire budget. Drives the CPU `interrupt` input and holds it until the handler acknowledges with a store to ACK_ADDR.
- Sits between the bench/config driver and the `mips` top. It observes `macroscopic_pc`, `m_int_addr` and `m_int_byteen`.

---
 rtl/int_injector_if.sv | 32 +++
 rtl/int_injector.sv | 168 ++++++++++++++++
 tb/tb_int_injector.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_injector_if.sv
// Bench-side bus of the interrupt injector: CPU observation, trigger config and status.
// The master modport drives the CPU/config side; the slave modport is the injector.
interface int_injector_if #(
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 4,
    parameter int TOTAL_W = 16
);
    logic [31:0]        macroscopic_pc;
    logic [31:0]        m_int_addr;
    logic [3:0]         m_int_byteen;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [31:0]        cfg_pc;
    logic [CNT_W-1:0]   cfg_count;
    logic               interrupt;
    logic [IDX_W-1:0]   fire_idx;
    logic [TOTAL_W-1:0] fire_total;
    logic               busy;
    logic               timeout_err;

    modport master (
        output macroscopic_pc, m_int_addr, m_int_byteen,
        output cfg_we, cfg_idx, cfg_pc, cfg_count,
        input  interrupt, fire_idx, fire_total, busy, timeout_err
    );

    modport slave (
        input  macroscopic_pc, m_int_addr, m_int_byteen,
        input  cfg_we, cfg_idx, cfg_pc, cfg_count,
        output interrupt, fire_idx, fire_total, busy, timeout_err
    );
endinterface

// File: rtl/int_injector.sv
// Multi-channel PC-triggered interrupt generator for the P7 MIPS bench.
// Optional macro INT_INJ_TIMEOUT_EN adds a no-ack timeout with sticky timeout_err.
module int_inj_chan #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [31:0]      ld_pc,
    input  logic [CNT_W-1:0] ld_cnt,
    input  logic             dec,
    input  logic [31:0]      cur_pc,
    output logic             match
);
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;

    // A config load beats a same-edge decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= '0;
            cnt <= '0;
        end else if (ld) begin
            pc  <= ld_pc;
            cnt <= ld_cnt;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign match = (cnt != '0) && ((cur_pc & ~32'h3) == (pc & ~32'h3));
endmodule

module int_injector #(
    parameter int          NUM_TRIG = 4,
    parameter int          CNT_W    = 4,
    parameter logic [31:0] ACK_ADDR = 32'h0000_7f20,
    parameter int          HOLDOFF  = 2,
    parameter int          TIMEOUT  = 1024,
    parameter int          TOTAL_W  = 16
) (
    input logic           clk,
    input logic           reset,
    int_injector_if.slave bus
);
    localparam int IDX_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;
    localparam int HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    if (NUM_TRIG < 1 || NUM_TRIG > 16 || TIMEOUT < 1) begin : g_param_check
        $error("int_injector: NUM_TRIG must be 1..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

    state_t              state;
    logic [HW-1:0]       hcnt;
    logic [NUM_TRIG-1:0] match, ld, dec;
    logic                any_match;
    logic [IDX_W-1:0]    winner;
    logic                ack;
    logic                to_hit;

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_chan
        // Out-of-range cfg_idx matches no channel, so it is dropped here.
        assign ld[i]  = bus.cfg_we && (bus.cfg_idx == IDX_W'(i));
        assign dec[i] = (state == IDLE) && any_match && (winner == IDX_W'(i));

        int_inj_chan #(.CNT_W(CNT_W)) u_chan (
            .clk    (clk),
            .reset  (reset),
            .ld     (ld[i]),
            .ld_pc  (bus.cfg_pc),
            .ld_cnt (bus.cfg_count),
            .dec    (dec[i]),
            .cur_pc (bus.macroscopic_pc),
            .match  (match[i])
        );
    end

    // Lowest matching index wins: scan downward so the last hit is the lowest.
    always_comb begin
        any_match = 1'b0;
        winner    = '0;
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_match = 1'b1;
                winner    = IDX_W'(i);
            end
        end
    end

    assign ack = (|bus.m_int_byteen) && ((bus.m_int_addr & ~32'h3) == ACK_ADDR);

`ifdef INT_INJ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt;
    logic          terr;

    assign to_hit          = (tcnt == TW'(TIMEOUT - 1));
    assign bus.timeout_err = terr;

    // An ack on the timeout cycle wins and leaves the error flag alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
            terr <= 1'b0;
        end else if (state == ASSERT) begin
            if (!ack && to_hit) terr <= 1'b1;
            tcnt <= (ack || to_hit) ? '0 : tcnt + TW'(1);
        end else begin
            tcnt <= '0;
        end
    end
`else
    assign to_hit          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hcnt           <= '0;
            bus.interrupt  <= 1'b0;
            bus.fire_idx   <= '0;
            bus.fire_total <= '0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_match) begin
                        state         <= ASSERT;
                        bus.interrupt <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.fire_idx  <= winner;
                        if (bus.fire_total != '1)
                            bus.fire_total <= bus.fire_total + TOTAL_W'(1);
                    end
                end
                ASSERT: begin
                    if (ack || to_hit) begin
                        bus.interrupt <= 1'b0;
                        if (HOLDOFF == 0) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= HOLD;
                            hcnt  <= HW'(HOLDOFF);
                        end
                    end
                end
                HOLD: begin
                    if (hcnt <= HW'(1)) begin
                        state    <= IDLE;
                        hcnt     <= '0;
                        bus.busy <= 1'b0;
                    end else begin
                        hcnt <= hcnt - HW'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.interrupt <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_int_injector.sv
// Self-checking bench for int_injector: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of triggers, budgets and holdoff.
module tb_int_injector;
    localparam int          NT      = 3;
    localparam int          IDX_W   = 2;
    localparam int          CNT_W   = 4;
    localparam int          TOTAL_W = 16;
    localparam int          HOLDOFF = 2;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] ACK     = 32'h0000_7f20;
    localparam logic [31:0] IDLE_PC = 32'h0000_3000;
    localparam int          TUP_W   = 3 + IDX_W + TOTAL_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_injector_if #(.IDX_W(IDX_W), .CNT_W(CNT_W), .TOTAL_W(TOTAL_W)) bus ();

    int_injector #(
        .NUM_TRIG (NT),
        .CNT_W    (CNT_W),
        .ACK_ADDR (ACK),
        .HOLDOFF  (HOLDOFF),
        .TIMEOUT  (TIMEOUT),
        .TOTAL_W  (TOTAL_W)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // Reference model state
    logic [31:0] m_pc[NT];
    int          m_cnt[NT];
    bit          m_int, m_terr;
    int          m_idx, m_total, m_hold, m_hi;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void model_step();
        int win;
        bit ak;
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                m_pc[i]  = '0;
                m_cnt[i] = 0;
            end
            m_int = 0; m_terr = 0; m_idx = 0; m_total = 0; m_hold = 0; m_hi = 0;
            return;
        end
        win = -1;
        for (int i = NT - 1; i >= 0; i--)
            if (m_cnt[i] != 0 && (bus.macroscopic_pc >> 2) == (m_pc[i] >> 2)) win = i;
        ak = (bus.m_int_byteen != 4'h0) && ((bus.m_int_addr >> 2) == (ACK >> 2));
        if (m_int) begin
            m_hi++;
            if (ak) begin
                m_int  = 0;
                m_hold = HOLDOFF;
            end
`ifdef INT_INJ_TIMEOUT_EN
            else if (m_hi == TIMEOUT) begin
                m_int  = 0;
                m_terr = 1;
                m_hold = HOLDOFF;
            end
`endif
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (win >= 0) begin
            m_int = 1;
            m_idx = win;
            m_hi  = 0;
            m_cnt[win]--;
            if (m_total < (1 << TOTAL_W) - 1) m_total++;
        end
        if (bus.cfg_we && bus.cfg_idx < NT) begin
            m_pc[bus.cfg_idx]  = bus.cfg_pc;
            m_cnt[bus.cfg_idx] = int'(bus.cfg_count);
        end
    endfunction

    function automatic logic [TUP_W-1:0] exp_t();
        return {m_int, IDX_W'(m_idx), TOTAL_W'(m_total), (m_int || m_hold > 0), m_terr};
    endfunction

    function automatic logic [TUP_W-1:0] dut_t();
        return {bus.interrupt, bus.fire_idx, bus.fire_total, bus.busy, bus.timeout_err};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input bit ak, input bit we = 1'b0,
                         input logic [IDX_W-1:0] idx = '0, input logic [31:0] cpc = '0,
                         input logic [CNT_W-1:0] ccnt = '0);
        bus.macroscopic_pc = pc;
        bus.m_int_addr     = ak ? ACK : 32'h0000_7f00;
        bus.m_int_byteen   = ak ? 4'hf : 4'h0;
        bus.cfg_we         = we;
        bus.cfg_idx        = idx;
        bus.cfg_pc         = cpc;
        bus.cfg_count      = ccnt;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_t() !== '0) $display("FAIL reset_state got %h want 0", dut_t());
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        drive(IDLE_PC, 0, 1, 2'd0, 32'h3014, 4'd1);
        drive(32'h3014, 0);
        n_checks++;
        if ({bus.interrupt, bus.fire_idx, bus.fire_total} !== {1'b1, 2'd0, 16'd1})
            $display("FAIL basic_fire got %b/%0d/%0d want 1/0/1", bus.interrupt, bus.fire_idx, bus.fire_total);
        else n_pass++;
        drive(IDLE_PC, 1);
        n_checks++;
        if (bus.interrupt !== 1'b0) $display("FAIL basic_ack interrupt got %b want 0", bus.interrupt);
        else n_pass++;
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
        drive(32'h3014, 0);
        n_checks++;
        if ({bus.interrupt, bus.fire_total} !== {1'b0, 16'd1})
            $display("FAIL basic_exhausted got %b/%0d want 0/1", bus.interrupt, bus.fire_total);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        drive(IDLE_PC, 0, 1, 2'd1, 32'h3020, 4'd2);
        drive(IDLE_PC, 0, 1, 2'd2, 32'h3020, 4'd2);
        for (int v = 0; v < 5; v++) begin
            drive(32'h3020, 0);
            n_checks++;
            if (bus.interrupt !== (v < 4))
                $display("FAIL prio_fire visit %0d interrupt got %b want %b", v, bus.interrupt, (v < 4));
            else n_pass++;
            if (v < 4) begin
                n_checks++;
                if (bus.fire_idx !== ((v < 2) ? 2'd1 : 2'd2))
                    $display("FAIL prio_idx visit %0d got %0d want %0d", v, bus.fire_idx, (v < 2) ? 1 : 2);
                else n_pass++;
            end
            drive(IDLE_PC, 1);
            drive(IDLE_PC, 0);
            drive(IDLE_PC, 0);
        end
        n_checks++;
        if (bus.fire_total !== 16'd4) $display("FAIL prio_total got %0d want 4", bus.fire_total);
        else n_pass++;
    endtask

    task automatic test_holdoff();
        do_reset();
        drive(IDLE_PC, 0, 1, 2'd0, 32'h3014, 4'd3);
        drive(32'h3014, 0);
        drive(IDLE_PC, 1);
        drive(32'h3014, 0);
        n_checks++;
        if (bus.interrupt !== 1'b0) $display("FAIL holdoff_block interrupt got %b want 0", bus.interrupt);
        else n_pass++;
        drive(IDLE_PC, 0);
        drive(32'h3014, 0);
        n_checks++;
        if ({bus.interrupt, bus.fire_total} !== {1'b1, 16'd2})
            $display("FAIL holdoff_rearm got %b/%0d want 1/2", bus.interrupt, bus.fire_total);
        else n_pass++;
        drive(32'h3014, 1);
        n_checks++;
        if ({bus.interrupt, bus.busy, bus.fire_total} !== {1'b0, 1'b1, 16'd2})
            $display("FAIL ack_with_match got %b/%b/%0d want 0/1/2", bus.interrupt, bus.busy, bus.fire_total);
        else n_pass++;
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
        drive(32'h3014, 0);
        n_checks++;
        if ({bus.interrupt, bus.fire_total} !== {1'b1, 16'd3})
            $display("FAIL no_extra_dec got %b/%0d want 1/3", bus.interrupt, bus.fire_total);
        else n_pass++;
        drive(IDLE_PC, 1);
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
        drive(32'h3014, 0);
        n_checks++;
        if (bus.interrupt !== 1'b0) $display("FAIL budget_spent interrupt got %b want 0", bus.interrupt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(IDLE_PC, 0, 1, 2'd2, 32'h3040, 4'd5);
        drive(32'h3040, 0);
        rst = 1'b1;
        drive(32'h3040, 0);
        rst = 1'b0;
        n_checks++;
        if ({bus.interrupt, bus.busy, bus.fire_total} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL reset_mid got %b/%b/%0d want 0/0/0", bus.interrupt, bus.busy, bus.fire_total);
        else n_pass++;
        drive(32'h3040, 0);
        n_checks++;
        if (bus.interrupt !== 1'b0) $display("FAIL reset_disables interrupt got %b want 0", bus.interrupt);
        else n_pass++;
    endtask

    task automatic test_cfg_edge();
        do_reset();
        drive(IDLE_PC, 0, 1, 2'd0, 32'h3014, 4'd1);
        drive(32'h3014, 0, 1, 2'd0, 32'h3014, 4'd3);
        n_checks++;
        if ({bus.interrupt, bus.fire_idx} !== {1'b1, 2'd0})
            $display("FAIL cfg_same_cycle got %b/%0d want 1/0", bus.interrupt, bus.fire_idx);
        else n_pass++;
        drive(IDLE_PC, 1);
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
        drive(32'h3014, 0);
        n_checks++;
        if ({bus.interrupt, bus.fire_total} !== {1'b1, 16'd2})
            $display("FAIL cfg_wins_dec got %b/%0d want 1/2", bus.interrupt, bus.fire_total);
        else n_pass++;
        drive(IDLE_PC, 1);
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0, 1, 2'd3, 32'h3100, 4'd2);
        drive(32'h3100, 0);
        n_checks++;
        if (bus.interrupt !== 1'b0) $display("FAIL cfg_out_of_range interrupt got %b want 0", bus.interrupt);
        else n_pass++;
        drive(32'h3016, 0);
        n_checks++;
        if ({bus.interrupt, bus.fire_idx, bus.fire_total} !== {1'b1, 2'd0, 16'd3})
            $display("FAIL low_bits_masked got %b/%0d/%0d want 1/0/3", bus.interrupt, bus.fire_idx, bus.fire_total);
        else n_pass++;
        drive(IDLE_PC, 1);
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        drive(IDLE_PC, 0, 1, 2'd0, 32'h3014, 4'd1);
        drive(32'h3014, 0);
`ifdef INT_INJ_TIMEOUT_EN
        hi = 0;
        for (int k = 0; k < 20 && bus.interrupt; k++) begin
            hi++;
            drive(IDLE_PC, 0);
        end
        n_checks++;
        if (hi != TIMEOUT) $display("FAIL timeout_len high cycles got %0d want %0d", hi, TIMEOUT);
        else n_pass++;
        drive(IDLE_PC, 1);
        drive(IDLE_PC, 0);
        drive(IDLE_PC, 0);
        n_checks++;
        if ({bus.interrupt, bus.timeout_err} !== 2'b01)
            $display("FAIL timeout_sticky got %b/%b want 0/1", bus.interrupt, bus.timeout_err);
        else n_pass++;
        do_reset();
        n_checks++;
        if (bus.timeout_err !== 1'b0) $display("FAIL timeout_reset got %b want 0", bus.timeout_err);
        else n_pass++;
`else
        hi = 0;
        for (int k = 0; k < 2000; k++) begin
            drive(IDLE_PC, 0);
            if (bus.interrupt) hi++;
        end
        n_checks++;
        if ({bus.interrupt, bus.timeout_err} !== 2'b10 || hi != 2000)
            $display("FAIL no_timeout got %b/%b high %0d want 1/0 high 2000", bus.interrupt, bus.timeout_err, hi);
        else n_pass++;
        drive(IDLE_PC, 1);
`endif
    endtask

    task automatic test_random();
        logic [31:0] pool[4];
        pool[0] = 32'h3014; pool[1] = 32'h3020; pool[2] = 32'h3040; pool[3] = 32'h3100;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.macroscopic_pc = ($urandom_range(0, 3) == 0) ? IDLE_PC
                               : (pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) begin
                bus.m_int_addr   = ACK | 32'($urandom_range(0, 3));
                bus.m_int_byteen = 4'($urandom_range(0, 15));
            end else begin
                bus.m_int_addr   = 32'h7f00 + 32'($urandom_range(0, 15));
                bus.m_int_byteen = 4'($urandom_range(0, 15));
            end
            bus.cfg_we    = ($urandom_range(0, 4) == 0);
            bus.cfg_idx   = IDX_W'($urandom_range(0, 3));
            bus.cfg_pc    = pool[$urandom_range(0, 3)];
            bus.cfg_count = CNT_W'($urandom_range(0, 3));
            tick();
            n_checks++;
            if (dut_t() !== exp_t())
                $display("FAIL random cycle %0d got %h want %h", c, dut_t(), exp_t());
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_priority();
        test_holdoff();
        test_reset_mid();
        test_cfg_edge();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
